// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one FP_Unit among NUM_REQ requesters,
// with latched operands, start/stall sequencing, done/err pulses and a hang timeout.
module fp_unit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                   iClk,
   input  logic                   iReset_n,
   input  logic [NUM_REQ-1:0]     iReq,
   input  logic [2*NUM_REQ-1:0]   iOp,
   input  logic [32*NUM_REQ-1:0]  iRs1,
   input  logic [32*NUM_REQ-1:0]  iRs2,
   output logic [NUM_REQ-1:0]     oGnt,
   output logic [NUM_REQ-1:0]     oDone,
   output logic [NUM_REQ-1:0]     oErr,
   output logic [31:0]            oResult,
   output logic                   oBusy,
   output logic                   oFpuStart,
   output logic [1:0]             oFpuOp,
   output logic [31:0]            oFpuRs1,
   output logic [31:0]            oFpuRs2,
   input  logic [31:0]            iFpuData,
   input  logic                   iFpuStall
);
   localparam int PW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_n;
   logic [PW-1:0] ptr, own, win;
   logic found, err, timeout_hit;
   logic [7:0] cnt;
   // first requester at or above ptr, wrapping around
   always_comb begin
      win = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (!found && iReq[(int'(ptr) + i) % NUM_REQ]) begin
            win = PW'((int'(ptr) + i) % NUM_REQ);
            found = 1'b1;
         end
   end
   assign timeout_hit = (TIMEOUT != 0) && (cnt + 8'd1 == 8'(TIMEOUT));
   always_ff @(posedge iClk or negedge iReset_n)
      if (!iReset_n) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = found ? ISSUE : IDLE;
         ISSUE:   state_n = WAIT;
         WAIT:    state_n = (!iFpuStall || timeout_hit) ? DONE : WAIT;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge iClk or negedge iReset_n)
      if (!iReset_n) begin
         ptr       <= '0;
         own       <= '0;
         err       <= 1'b0;
         cnt       <= '0;
         oGnt      <= '0;
         oResult   <= '0;
         oFpuStart <= 1'b0;
         oFpuOp    <= '0;
         oFpuRs1   <= '0;
         oFpuRs2   <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               own     <= win;
               oGnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
               oFpuOp  <= iOp[2*win +: 2];
               oFpuRs1 <= iRs1[32*win +: 32];
               oFpuRs2 <= iRs2[32*win +: 32];
               err     <= 1'b0;
            end
            ISSUE: begin
               oFpuStart <= 1'b1;
               cnt       <= '0;
            end
            WAIT: if (!iFpuStall) begin
               oResult   <= iFpuData;
               oFpuStart <= 1'b0;
            end else begin
               cnt <= cnt + 8'd1;
               if (timeout_hit) begin
                  oFpuStart <= 1'b0;
                  err       <= 1'b1;
               end
            end
            default: begin
               ptr  <= (own == PW'(NUM_REQ - 1)) ? '0 : own + 1'b1;
               oGnt <= '0;
            end
         endcase
      end
   assign oBusy = state != IDLE;
   assign oDone = (state == DONE && !err) ? oGnt : '0;
   assign oErr  = (state == DONE && err) ? oGnt : '0;
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter: randomized and directed checks of fp_unit_arbiter against a
// round-robin reference model and a behavioural FP_Unit stand-in.
module tb_fp_unit_arbiter;
   localparam int N = 4;
   localparam int TO = 8;
   logic iClk = 1'b0;
   logic iReset_n = 1'b0;
   logic [N-1:0] iReq = '0;
   logic [2*N-1:0] iOp;
   logic [32*N-1:0] iRs1, iRs2;
   logic [N-1:0] oGnt, oDone, oErr;
   logic [31:0] oResult, oFpuRs1, oFpuRs2, iFpuData;
   logic [1:0] oFpuOp;
   logic oBusy, oFpuStart, iFpuStall;
   logic [1:0] op_v [N];
   logic [31:0] rs1_v [N];
   logic [31:0] rs2_v [N];
   int total = 0, bad = 0, rr_ptr = 0, stall_n = 0, fpu_cyc = 0;
   logic stuck = 1'b0;
   logic [31:0] exp_last = '0;

   fp_unit_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .iClk(iClk), .iReset_n(iReset_n), .iReq(iReq), .iOp(iOp), .iRs1(iRs1), .iRs2(iRs2),
      .oGnt(oGnt), .oDone(oDone), .oErr(oErr), .oResult(oResult), .oBusy(oBusy),
      .oFpuStart(oFpuStart), .oFpuOp(oFpuOp), .oFpuRs1(oFpuRs1), .oFpuRs2(oFpuRs2),
      .iFpuData(iFpuData), .iFpuStall(iFpuStall)
   );

   always #5 iClk = ~iClk;

   always_comb
      for (int i = 0; i < N; i++) begin
         iOp[2*i +: 2]   = op_v[i];
         iRs1[32*i +: 32] = rs1_v[i];
         iRs2[32*i +: 32] = rs2_v[i];
      end

   function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (a * 3 + b) ^ {op, 30'h0};
   endfunction

   // FP_Unit stand-in: stalls stall_n cycles after sampling start (or forever when stuck)
   assign iFpuData  = fpu_fn(oFpuOp, oFpuRs1, oFpuRs2);
   assign iFpuStall = oFpuStart && (stuck || fpu_cyc < stall_n);
   always @(posedge iClk) fpu_cyc <= oFpuStart ? fpu_cyc + 1 : 0;

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++)
         if (r[(p + i) % N]) return (p + i) % N;
      return 0;
   endfunction

   function automatic logic [N-1:0] onehot(input int k);
      logic [N-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic randomize_ops();
      for (int i = 0; i < N; i++) begin
         op_v[i]  = 2'($urandom);
         rs1_v[i] = $urandom;
         rs2_v[i] = $urandom;
      end
   endtask

   // advance until a done/err pulse (bounded); reports last grant, cycles and start cycles
   task automatic wait_done(input bit scramble, output logic [N-1:0] g, output int cyc, output int st);
      g = '0;
      cyc = 0;
      st = 0;
      while (cyc < 60 && (oDone | oErr) == '0) begin
         @(negedge iClk);
         cyc++;
         if (oGnt != '0) g = oGnt;
         if (oFpuStart) st++;
         if (scramble && cyc == 2) begin
            randomize_ops();
            iReq = N'($urandom);
         end
      end
   endtask

   task automatic test_reset();
      iReq = '0;
      randomize_ops();
      repeat (2) @(negedge iClk);
      total++; if ({oGnt, oDone, oErr, oBusy} !== '0) begin bad++; $display("FAIL reset_ctl got=%b want=0", {oGnt, oDone, oErr, oBusy}); end
      total++; if ({oFpuStart, oFpuOp, oFpuRs1, oFpuRs2} !== '0) begin bad++; $display("FAIL reset_fpu got=%h want=0", {oFpuStart, oFpuOp, oFpuRs1, oFpuRs2}); end
      total++; if (oResult !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", oResult); end
      iReset_n = 1'b1;
      rr_ptr = 0;
      repeat (2) @(negedge iClk);
      total++; if ({oBusy, oGnt} !== '0) begin bad++; $display("FAIL idle_noreq got=%b want=0", {oBusy, oGnt}); end
   endtask

   task automatic test_single();
      logic [N-1:0] g;
      int cyc, st;
      logic [31:0] er;
      op_v[0] = 2'd0; rs1_v[0] = 32'h3F800000; rs2_v[0] = 32'h40000000;
      stall_n = 2;
      er = fpu_fn(2'd0, 32'h3F800000, 32'h40000000);
      iReq = 4'b0001;
      wait_done(1'b0, g, cyc, st);
      total++; if (g !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", g); end
      total++; if (oDone !== 4'b0001 || oErr !== '0) begin bad++; $display("FAIL single_done got=%b/%b want=0001/0000", oDone, oErr); end
      total++; if (oResult !== er) begin bad++; $display("FAIL single_result got=%h want=%h", oResult, er); end
      total++; if (cyc !== 5) begin bad++; $display("FAIL single_latency got=%0d want=5", cyc); end
      total++; if (st !== 3) begin bad++; $display("FAIL single_start_len got=%0d want=3", st); end
      rr_ptr = 1; exp_last = er;
      iReq = '0;
      @(negedge iClk);
      total++; if ({oDone, oBusy, oGnt} !== '0) begin bad++; $display("FAIL single_after got=%b want=0", {oDone, oBusy, oGnt}); end
      total++; if (oResult !== er) begin bad++; $display("FAIL single_hold got=%h want=%h", oResult, er); end
   endtask

   task automatic test_all_four();
      logic [N-1:0] g;
      int cyc, st, w;
      logic [31:0] er;
      randomize_ops();
      iReq = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         stall_n = k % 3;
         w = pick(iReq, rr_ptr);
         er = fpu_fn(op_v[w], rs1_v[w], rs2_v[w]);
         wait_done(1'b0, g, cyc, st);
         total++; if (g !== onehot(w) || oDone !== onehot(w)) begin bad++; $display("FAIL rr_grant k=%0d got=%b/%b want=%b", k, g, oDone, onehot(w)); end
         total++; if (oResult !== er || cyc !== 3 + stall_n) begin bad++; $display("FAIL rr_result k=%0d got=%h,%0d want=%h,%0d", k, oResult, cyc, er, 3 + stall_n); end
         rr_ptr = (w + 1) % N; exp_last = er;
         if (k == 5) iReq = '0;
         @(negedge iClk);
         total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL rr_bubble k=%0d got=%b want=0", k, oBusy); end
      end
   endtask

   task automatic test_ptr();
      logic [N-1:0] g;
      int cyc, st, w;
      stall_n = 1;
      iReq = 4'b0010;
      wait_done(1'b0, g, cyc, st);
      rr_ptr = 2; exp_last = fpu_fn(op_v[1], rs1_v[1], rs2_v[1]);
      iReq = '0;
      @(negedge iClk);
      iReq = 4'b0010;
      wait_done(1'b0, g, cyc, st);
      total++; if (g !== 4'b0010 || cyc !== 4) begin bad++; $display("FAIL ptr_below got=%b,%0d want=0010,4", g, cyc); end
      iReq = '0;
      @(negedge iClk);
      iReq = 4'b1011;
      w = pick(iReq, rr_ptr);
      wait_done(1'b0, g, cyc, st);
      total++; if (g !== onehot(w)) begin bad++; $display("FAIL ptr_next got=%b want=%b", g, onehot(w)); end
      rr_ptr = (w + 1) % N; exp_last = fpu_fn(op_v[w], rs1_v[w], rs2_v[w]);
      iReq = '0;
      @(negedge iClk);
   endtask

   task automatic test_timeout();
      logic [N-1:0] g;
      int cyc, st, w;
      logic [31:0] er;
      randomize_ops();
      stuck = 1'b1;
      iReq = 4'b0110;
      w = pick(iReq, rr_ptr);
      wait_done(1'b0, g, cyc, st);
      total++; if (oErr !== onehot(w) || oDone !== '0) begin bad++; $display("FAIL timeout_err got=%b/%b want=%b/0000", oErr, oDone, onehot(w)); end
      total++; if (cyc !== 2 + TO) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", cyc, 2 + TO); end
      total++; if (oResult !== exp_last || oFpuStart !== 1'b0) begin bad++; $display("FAIL timeout_state got=%h,%b want=%h,0", oResult, oFpuStart, exp_last); end
      rr_ptr = (w + 1) % N;
      stuck = 1'b0;
      stall_n = 0;
      iReq = '0;
      @(negedge iClk);
      iReq = 4'b1111;
      w = pick(iReq, rr_ptr);
      er = fpu_fn(op_v[w], rs1_v[w], rs2_v[w]);
      wait_done(1'b0, g, cyc, st);
      total++; if (oDone !== onehot(w) || oResult !== er) begin bad++; $display("FAIL timeout_next got=%b,%h want=%b,%h", oDone, oResult, onehot(w), er); end
      rr_ptr = (w + 1) % N; exp_last = er;
      iReq = '0;
      @(negedge iClk);
   endtask

   task automatic test_latch();
      logic [N-1:0] g;
      int cyc, st, w;
      logic [31:0] old, er;
      randomize_ops();
      stall_n = 4;
      iReq = 4'b1000;
      w = 3;
      old = rs1_v[w];
      er = fpu_fn(op_v[w], rs1_v[w], rs2_v[w]);
      repeat (2) @(negedge iClk);
      rs1_v[w] = ~old;
      op_v[w] = ~op_v[w];
      @(negedge iClk);
      total++; if (oFpuRs1 !== old) begin bad++; $display("FAIL latch_rs1 got=%h want=%h", oFpuRs1, old); end
      wait_done(1'b0, g, cyc, st);
      total++; if (oDone !== onehot(w) || oResult !== er) begin bad++; $display("FAIL latch_result got=%b,%h want=%b,%h", oDone, oResult, onehot(w), er); end
      rr_ptr = (w + 1) % N; exp_last = er;
      iReq = '0;
      @(negedge iClk);
   endtask

   task automatic test_async_reset();
      logic [N-1:0] g;
      int cyc, st, seen;
      stall_n = 6;
      iReq = 4'b0100;
      repeat (3) @(negedge iClk);
      total++; if (oFpuStart !== 1'b1 || oBusy !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b%b want=11", oFpuStart, oBusy); end
      #2 iReset_n = 1'b0;
      #1;
      total++; if ({oGnt, oDone, oErr, oBusy, oFpuStart, oFpuOp, oFpuRs1, oFpuRs2, oResult} !== '0) begin bad++; $display("FAIL areset_outputs got=%h want=0", {oGnt, oDone, oErr, oBusy, oFpuStart, oFpuOp, oFpuRs1, oFpuRs2, oResult}); end
      iReq = '0;
      repeat (2) @(negedge iClk);
      iReset_n = 1'b1;
      rr_ptr = 0; exp_last = '0;
      seen = 0;
      repeat (10) begin
         @(negedge iClk);
         if ((oDone | oErr) != '0) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL areset_no_pulse got=%0d want=0", seen); end
      stall_n = 0;
      iReq = 4'b1111;
      wait_done(1'b0, g, cyc, st);
      total++; if (g !== 4'b0001) begin bad++; $display("FAIL areset_ptr got=%b want=0001", g); end
      rr_ptr = 1; exp_last = fpu_fn(op_v[0], rs1_v[0], rs2_v[0]);
      iReq = '0;
      @(negedge iClk);
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      int cyc, st, w;
      logic [31:0] er;
      for (int it = 0; it < 40; it++) begin
         randomize_ops();
         stall_n = $urandom_range(0, 6);
         iReq = N'($urandom_range(1, 15));
         w = pick(iReq, rr_ptr);
         er = fpu_fn(op_v[w], rs1_v[w], rs2_v[w]);
         wait_done(1'b1, g, cyc, st);
         total++; if (g !== onehot(w) || oDone !== onehot(w) || oErr !== '0) begin bad++; $display("FAIL rand_gnt it=%0d got=%b/%b/%b want=%b", it, g, oDone, oErr, onehot(w)); end
         total++; if (oResult !== er) begin bad++; $display("FAIL rand_result it=%0d got=%h want=%h", it, oResult, er); end
         total++; if (cyc !== 3 + stall_n || st !== 1 + stall_n) begin bad++; $display("FAIL rand_timing it=%0d got=%0d,%0d want=%0d,%0d", it, cyc, st, 3 + stall_n, 1 + stall_n); end
         rr_ptr = (w + 1) % N; exp_last = er;
         iReq = '0;
         @(negedge iClk);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_ptr();
      test_timeout();
      test_latch();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
